// File: rtl/nmr_pkg.sv
// rtl/nmr_pkg.sv - shared state encoding, TX codes and phase scan helper for the pulse sequencer
package nmr_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      DLY  = 3'd2,
      P2   = 3'd3,
      ACQ  = 3'd4
   } state_t;

   localparam logic [1:0] TX_OFF = 2'b00;

   // First phase at or after position 'from' (1=P1 .. 4=ACQ, 5=past ACQ) whose
   // length is non-zero; live[0]=P1 .. live[3]=ACQ. Returns IDLE when none is left.
   function automatic state_t scan_from(input logic [3:0] live, input logic [2:0] from);
      state_t r;
      r = IDLE;
      for (int i = 3; i >= 0; i--) begin
         if (live[i] && (3'(i + 1) >= from)) r = state_t'(3'(i + 1));
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with zero flag timing one phase
module phase_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // load on phase entry, otherwise count down and park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - P1/DLY/P2/ACQ pulse sequencer with repetitions and abort
module pulse_sequencer
   import nmr_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REP_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] p1_len,
   input  logic [CNT_W-1:0] dly_len,
   input  logic [CNT_W-1:0] p2_len,
   input  logic [CNT_W-1:0] acq_len,
   input  logic [REP_W-1:0] n_reps,
   input  logic [31:0]      frq_in,
   input  logic [1:0]       ph1,
   input  logic [1:0]       ph2,
   output logic             enable,
   output logic [31:0]      frq,
   output logic [1:0]       TX,
   output logic             rx_gate,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [REP_W-1:0] rep_cnt
);

   state_t state, state_nxt, rep_first, follow;
   logic [2:0] state_idx;

   logic [CNT_W-1:0] p1_sh, dly_sh, p2_sh, acq_sh;
   logic [CNT_W-1:0] p1_src, dly_src, p2_src, acq_src;
   logic [REP_W-1:0] n_sh, n_eff;
   logic [31:0]      frq_sh, frq_src;
   logic [1:0]       ph1_sh, ph2_sh, ph1_src, ph2_src;
   logic [3:0]       live;

   logic             load, tmr_zero;
   logic [CNT_W-1:0] load_val, rep_load, follow_load;
   logic             accept, rep_end, done_nxt, abort_nxt;
   logic [REP_W-1:0] rep_inc;

   logic             enable_d, rx_d, busy_d;
   logic [1:0]       tx_d;
   logic [31:0]      frq_d;

   // Counter preload for a phase: N-1, or 0 for the zero-length busy-only ACQ cycle.
   function automatic logic [CNT_W-1:0] load_for(input state_t s,
                                                 input logic [CNT_W-1:0] l1,
                                                 input logic [CNT_W-1:0] ld,
                                                 input logic [CNT_W-1:0] l2,
                                                 input logic [CNT_W-1:0] la);
      logic [CNT_W-1:0] len;
      case (s)
         P1:      len = l1;
         DLY:     len = ld;
         P2:      len = l2;
         ACQ:     len = la;
         default: len = '0;
      endcase
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   // In IDLE the live inputs decide the first phase; afterwards only the shadows count.
   assign p1_src  = (state == IDLE) ? p1_len  : p1_sh;
   assign dly_src = (state == IDLE) ? dly_len : dly_sh;
   assign p2_src  = (state == IDLE) ? p2_len  : p2_sh;
   assign acq_src = (state == IDLE) ? acq_len : acq_sh;
   assign frq_src = (state == IDLE) ? frq_in  : frq_sh;
   assign ph1_src = (state == IDLE) ? ph1     : ph1_sh;
   assign ph2_src = (state == IDLE) ? ph2     : ph2_sh;
   assign n_eff   = (n_reps == '0) ? REP_W'(1) : n_reps;

   assign live      = {acq_src != '0, p2_src != '0, dly_src != '0, p1_src != '0};
   assign state_idx = state;
   // an all-zero repetition still spends one busy cycle, parked in ACQ with rx_gate low
   assign rep_first   = (scan_from(live, 3'd1) == IDLE) ? ACQ : scan_from(live, 3'd1);
   assign follow      = scan_from(live, state_idx + 3'd1);
   assign rep_load    = load_for(rep_first, p1_src, dly_src, p2_src, acq_src);
   assign follow_load = load_for(follow, p1_src, dly_src, p2_src, acq_src);
   assign rep_inc     = rep_cnt + 1'b1;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .zero     (tmr_zero)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state: start/abort handling, zero-length skipping and repetition loop
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_val  = '0;
      accept    = 1'b0;
      rep_end   = 1'b0;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      if (state == IDLE) begin
         if (start && !abort) begin
            accept    = 1'b1;
            state_nxt = rep_first;
            load      = 1'b1;
            load_val  = rep_load;
         end
      end else if (abort) begin
         state_nxt = IDLE;
         abort_nxt = 1'b1;
         load      = 1'b1;
      end else if (tmr_zero) begin
         load = 1'b1;
         if (follow != IDLE) begin
            state_nxt = follow;
            load_val  = follow_load;
         end else begin
            rep_end = 1'b1;
            if (rep_inc == n_sh) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = rep_first;
               load_val  = rep_load;
            end
         end
      end
   end

   // output decode from the upcoming state so the registered outputs line up with it
   always_comb begin
      enable_d = (state_nxt == P1) || (state_nxt == P2);
      tx_d     = TX_OFF;
      if (state_nxt == P1) tx_d = ph1_src;
      if (state_nxt == P2) tx_d = ph2_src;
      rx_d     = (state_nxt == ACQ) && (acq_src != '0);
      busy_d   = (state_nxt != IDLE);
      frq_d    = busy_d ? frq_src : 32'd0;
   end

   // output registers and repetition counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable  <= 1'b0;
         TX      <= TX_OFF;
         rx_gate <= 1'b0;
         busy    <= 1'b0;
         frq     <= 32'd0;
         done    <= 1'b0;
         aborted <= 1'b0;
         rep_cnt <= '0;
      end else begin
         enable  <= enable_d;
         TX      <= tx_d;
         rx_gate <= rx_d;
         busy    <= busy_d;
         frq     <= frq_d;
         done    <= done_nxt;
         aborted <= abort_nxt;
         if (accept)       rep_cnt <= '0;
         else if (rep_end) rep_cnt <= rep_inc;
      end
   end

   // shadow registers captured on an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_sh  <= '0;
         dly_sh <= '0;
         p2_sh  <= '0;
         acq_sh <= '0;
         n_sh   <= '0;
         frq_sh <= 32'd0;
         ph1_sh <= TX_OFF;
         ph2_sh <= TX_OFF;
      end else if (accept) begin
         p1_sh  <= p1_len;
         dly_sh <= dly_len;
         p2_sh  <= p2_len;
         acq_sh <= acq_len;
         n_sh   <= n_eff;
         frq_sh <= frq_in;
         ph1_sh <= ph1;
         ph2_sh <= ph2;
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - scoreboard bench comparing run-length output segments
module tb_pulse_sequencer;

   typedef struct packed {
      logic        en;
      logic [1:0]  tx;
      logic        rx;
      logic        bsy;
      logic        dn;
      logic        ab;
      logic [31:0] f;
      logic [15:0] rep;
      logic [15:0] len;
   } seg_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] p1_len = '0, dly_len = '0, p2_len = '0, acq_len = '0;
   logic [15:0] n_reps = '0;
   logic [31:0] frq_in = '0;
   logic [1:0]  ph1 = '0, ph2 = '0;
   logic        enable, rx_gate, busy, done, aborted;
   logic [31:0] frq;
   logic [1:0]  TX;
   logic [15:0] rep_cnt;

   int   n_checks = 0;
   int   n_pass = 0;
   seg_t exp_q[$];
   seg_t cur;
   logic cur_valid = 1'b0;

   always #5 clk = ~clk;

   pulse_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .p1_len(p1_len), .dly_len(dly_len), .p2_len(p2_len), .acq_len(acq_len),
      .n_reps(n_reps), .frq_in(frq_in), .ph1(ph1), .ph2(ph2),
      .enable(enable), .frq(frq), .TX(TX), .rx_gate(rx_gate), .busy(busy),
      .done(done), .aborted(aborted), .rep_cnt(rep_cnt)
   );

   function automatic seg_t mk(input logic en, input logic [1:0] tx, input logic rx,
                               input logic bsy, input logic dn, input logic ab,
                               input logic [31:0] f, input logic [15:0] rep, input logic [15:0] len);
      seg_t s;
      s.en = en; s.tx = tx; s.rx = rx; s.bsy = bsy; s.dn = dn; s.ab = ab;
      s.f = f; s.rep = rep; s.len = len;
      return s;
   endfunction

   task automatic push(input logic en, input logic [1:0] tx, input logic rx,
                       input logic bsy, input logic dn, input logic ab,
                       input logic [31:0] f, input logic [15:0] rep, input logic [15:0] len);
      exp_q.push_back(mk(en, tx, rx, bsy, dn, ab, f, rep, len));
   endtask

   // expected segments of one normal repetition with all four phases non-zero
   task automatic push_rep(input logic [1:0] a, input logic [1:0] b, input logic [31:0] f,
                           input logic [15:0] rep, input logic [15:0] l1, input logic [15:0] ld,
                           input logic [15:0] l2, input logic [15:0] la);
      push(1, a, 0, 1, 0, 0, f, rep, l1);
      push(0, 2'b00, 0, 1, 0, 0, f, rep, ld);
      push(1, b, 0, 1, 0, 0, f, rep, l2);
      push(0, 2'b00, 1, 1, 0, 0, f, rep, la);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   task automatic close_seg();
      seg_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL seg_unexpected: got en=%b tx=%b rx=%b busy=%b done=%b ab=%b frq=%h rep=%0d len=%0d expected none",
                  cur.en, cur.tx, cur.rx, cur.bsy, cur.dn, cur.ab, cur.f, cur.rep, cur.len);
      end else begin
         e = exp_q.pop_front();
         if (e === cur) n_pass++;
         else $display("FAIL seg: got en=%b tx=%b rx=%b busy=%b done=%b ab=%b frq=%h rep=%0d len=%0d expected en=%b tx=%b rx=%b busy=%b done=%b ab=%b frq=%h rep=%0d len=%0d",
                       cur.en, cur.tx, cur.rx, cur.bsy, cur.dn, cur.ab, cur.f, cur.rep, cur.len,
                       e.en, e.tx, e.rx, e.bsy, e.dn, e.ab, e.f, e.rep, e.len);
      end
   endtask

   // monitor: run-length encode active output cycles and score each finished segment
   initial begin
      seg_t t, k;
      logic act;
      forever begin
         @(negedge clk);
         t   = mk(enable, TX, rx_gate, busy, done, aborted, frq, rep_cnt, 16'd0);
         act = (busy === 1'b1) || (done === 1'b1) || (aborted === 1'b1);
         k   = cur;
         k.len = 16'd0;
         if (cur_valid && (!act || (k !== t))) begin
            close_seg();
            cur_valid = 1'b0;
         end
         if (act) begin
            if (cur_valid) cur.len = cur.len + 16'd1;
            else begin
               cur = t;
               cur.len = 16'd1;
               cur_valid = 1'b1;
            end
         end
      end
   end

   task automatic cfg(input logic [31:0] a, input logic [31:0] d, input logic [31:0] b,
                      input logic [31:0] q, input logic [15:0] n, input logic [31:0] f,
                      input logic [1:0] x1, input logic [1:0] x2);
      p1_len = a; dly_len = d; p2_len = b; acq_len = q; n_reps = n; frq_in = f; ph1 = x1; ph2 = x2;
   endtask

   // returns at the negedge where cycle 1 (first P1 cycle) is visible
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // cycles counted from start as cycle 0; bounded wait for done or aborted
   task automatic wait_end(input int c0, output int c);
      c = c0;
      while (!(done === 1'b1 || aborted === 1'b1) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (c >= 3000) begin
         n_checks++;
         $display("FAIL timeout: got no done/aborted after %0d cycles expected one", c);
      end
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      chk("rst_enable", enable, 0);
      chk("rst_tx", TX, 0);
      chk("rst_rx", rx_gate, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_frq", frq, 0);
      chk("rst_rep", rep_cnt, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_aborted", aborted, 0);

      // basic single repetition
      cfg(5, 10, 10, 20, 1, 32'h1234_5678, 2'b10, 2'b01);
      push_rep(2'b10, 2'b01, 32'h1234_5678, 0, 5, 10, 10, 20);
      push(0, 0, 0, 0, 1, 0, 0, 1, 1);
      pulse_start();
      wait_end(1, c);
      chk("basic_done_cycle", c, 46);
      repeat (4) @(negedge clk);

      // three back-to-back repetitions
      cfg(5, 10, 10, 20, 3, 32'hCAFE_0003, 2'b10, 2'b01);
      for (int r = 0; r < 3; r++) push_rep(2'b10, 2'b01, 32'hCAFE_0003, 16'(r), 5, 10, 10, 20);
      push(0, 0, 0, 0, 1, 0, 0, 3, 1);
      pulse_start();
      wait_end(1, c);
      chk("reps3_done_cycle", c, 136);
      repeat (2) @(negedge clk);
      chk("reps3_rep_hold", rep_cnt, 3);

      // zero DLY and P2, n_reps=0 treated as one
      cfg(5, 0, 0, 7, 0, 32'h0000_00A5, 2'b11, 2'b01);
      push(1, 2'b11, 0, 1, 0, 0, 32'hA5, 0, 5);
      push(0, 0, 1, 1, 0, 0, 32'hA5, 0, 7);
      push(0, 0, 0, 0, 1, 0, 0, 1, 1);
      pulse_start();
      wait_end(1, c);
      chk("skip_done_cycle", c, 13);
      repeat (3) @(negedge clk);

      // abort on the third P2 cycle
      cfg(2, 3, 6, 4, 1, 32'h0BAD_0001, 2'b01, 2'b10);
      push(1, 2'b01, 0, 1, 0, 0, 32'h0BAD_0001, 0, 2);
      push(0, 0, 0, 1, 0, 0, 32'h0BAD_0001, 0, 3);
      push(1, 2'b10, 0, 1, 0, 0, 32'h0BAD_0001, 0, 3);
      push(0, 0, 0, 0, 0, 1, 0, 0, 1);
      pulse_start();
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_enable", enable, 0);
      chk("abort_pulse", aborted, 1);
      chk("abort_no_done", done, 0);
      repeat (8) @(negedge clk);

      // abort and start together in IDLE: nothing happens
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      chk("abort_start_aborted", aborted, 0);
      @(negedge clk);
      chk("abort_start_busy2", busy, 0);

      // every phase zero, two repetitions
      cfg(0, 0, 0, 0, 2, 32'h0000_0077, 2'b10, 2'b01);
      push(0, 0, 0, 1, 0, 0, 32'h77, 0, 1);
      push(0, 0, 0, 1, 0, 0, 32'h77, 1, 1);
      push(0, 0, 0, 0, 1, 0, 0, 2, 1);
      pulse_start();
      wait_end(1, c);
      chk("allzero_done_cycle", c, 3);
      repeat (3) @(negedge clk);

      // start retriggered and inputs changed mid-sequence
      cfg(4, 2, 3, 2, 2, 32'h5555_AAAA, 2'b10, 2'b01);
      push_rep(2'b10, 2'b01, 32'h5555_AAAA, 0, 4, 2, 3, 2);
      push_rep(2'b10, 2'b01, 32'h5555_AAAA, 1, 4, 2, 3, 2);
      push(0, 0, 0, 0, 1, 0, 0, 2, 1);
      pulse_start();
      repeat (2) @(negedge clk);
      p1_len = 9; ph1 = 2'b11; frq_in = 32'h1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end(4, c);
      chk("retrig_done_cycle", c, 23);
      repeat (3) @(negedge clk);

      // reset in the middle of P1, then a clean run
      cfg(10, 2, 2, 2, 1, 32'hDEAD_BEEF, 2'b11, 2'b10);
      push(1, 2'b11, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 4);
      pulse_start();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_enable", enable, 0);
      chk("arst_tx", TX, 0);
      chk("arst_busy", busy, 0);
      chk("arst_frq", frq, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      cfg(5, 0, 0, 7, 1, 32'h0000_00A6, 2'b01, 2'b10);
      push(1, 2'b01, 0, 1, 0, 0, 32'hA6, 0, 5);
      push(0, 0, 1, 1, 0, 0, 32'hA6, 0, 7);
      push(0, 0, 0, 0, 1, 0, 0, 1, 1);
      pulse_start();
      wait_end(1, c);
      chk("after_rst_done_cycle", c, 13);
      repeat (5) @(negedge clk);

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
